// File: rtl/mbinit_stage_sequencer.sv
// ============================================================================
//  Module   : mbinit_stage_sequencer
//  Purpose  : Runs the MBINIT sub-state modules one at a time in a fixed order,
//             with a per-stage timeout and a shared-sideband start gate.
//  Options  : MBINIT_STAGE_RETRY_EN - allow one retry of a failed stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbinit_stage_sequencer #(
    parameter int NUM_STAGES     = 6,
    parameter int TIMEOUT_CYCLES = 8000000,
    parameter int TIMER_W        = 24
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  i_MBINIT_en,
    input  logic                  i_Busy_SideBand,
    input  logic [NUM_STAGES-1:0] i_stage_end,
    input  logic [NUM_STAGES-1:0] i_stage_error,
    output logic [NUM_STAGES-1:0] o_stage_en,
    output logic [2:0]            o_stage_idx,
    output logic                  o_MBINIT_done,
    output logic                  o_train_error_req,
    output logic                  o_timeout,
    output logic                  o_retried
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0]    c_TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]            c_LAST_IDX   = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] c_ONE        = NUM_STAGES'(1);

    state_t               r_state;
    state_t               w_state_n;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_n;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_n;
    logic                 r_gap_adv;
    logic                 w_gap_adv_n;
    logic                 r_timeout;
    logic                 w_timeout_n;
    logic                 w_take_retry;
    logic                 w_retry_avail;

    logic [NUM_STAGES-1:0] r_stage_en;
    logic                  r_done;
    logic                  r_err;

    // Stage inputs padded to the full index range so any idx selects a defined bit
    logic [7:0] w_end_vec;
    logic [7:0] w_err_vec;
    logic       w_end_sel;
    logic       w_err_sel;
    logic       w_timer_hit;

    assign w_end_vec   = 8'(i_stage_end);
    assign w_err_vec   = 8'(i_stage_error);
    assign w_end_sel   = w_end_vec[r_idx];
    assign w_err_sel   = w_err_vec[r_idx];
    assign w_timer_hit = (r_timer == c_TIMER_LAST);

`ifdef MBINIT_STAGE_RETRY_EN
    logic r_retried;

    assign w_retry_avail = ~r_retried;

    always_ff @(posedge CLK) begin
        if (rst || (w_state_n == ST_IDLE)) begin
            r_retried <= 1'b0;
        end else if (w_take_retry) begin
            r_retried <= 1'b1;
        end
    end

    assign o_retried = r_retried;
`else
    assign w_retry_avail = 1'b0;
    assign o_retried     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 3'd0;
            r_timer   <= '0;
            r_gap_adv <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_timer   <= w_timer_n;
            r_gap_adv <= w_gap_adv_n;
            r_timeout <= w_timeout_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_idx_n      = r_idx;
        w_timer_n    = r_timer;
        w_gap_adv_n  = r_gap_adv;
        w_timeout_n  = r_timeout;
        w_take_retry = 1'b0;

        if (!i_MBINIT_en) begin
            w_state_n   = ST_IDLE;
            w_idx_n     = 3'd0;
            w_timer_n   = '0;
            w_gap_adv_n = 1'b0;
            w_timeout_n = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_idx_n     = 3'd0;
                    w_timer_n   = '0;
                    w_timeout_n = 1'b0;
                    w_state_n   = ST_START;
                end
                ST_START: begin
                    if (!i_Busy_SideBand) begin
                        w_state_n = ST_RUN;
                        w_timer_n = '0;
                    end
                end
                ST_RUN: begin
                    w_timer_n = r_timer + 1'b1;
                    if (w_err_sel || w_timer_hit) begin
                        if (w_retry_avail) begin
                            w_take_retry = 1'b1;
                            w_gap_adv_n  = 1'b0;
                            w_state_n    = ST_GAP;
                        end else begin
                            w_timeout_n = ~w_err_sel;
                            w_state_n   = ST_ERROR;
                        end
                    end else if (w_end_sel) begin
                        w_gap_adv_n = 1'b1;
                        w_state_n   = (r_idx == c_LAST_IDX) ? ST_DONE : ST_GAP;
                    end
                end
                // Enable is low for this one cycle; a retried stage keeps its idx
                ST_GAP: begin
                    if (r_gap_adv) begin
                        w_idx_n = r_idx + 3'd1;
                    end
                    w_state_n = ST_START;
                end
                ST_DONE:  w_state_n = ST_DONE;
                ST_ERROR: w_state_n = ST_ERROR;
                default: begin
                    w_state_n = ST_IDLE;
                    w_idx_n   = 3'd0;
                    w_timer_n = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with r_state
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_stage_en <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_stage_en <= (w_state_n == ST_RUN) ? (c_ONE << w_idx_n) : '0;
            r_done     <= (w_state_n == ST_DONE);
            r_err      <= (w_state_n == ST_ERROR);
        end
    end

    assign o_stage_en        = r_stage_en;
    assign o_stage_idx       = r_idx;
    assign o_MBINIT_done     = r_done;
    assign o_train_error_req = r_err;
    assign o_timeout         = r_timeout;

endmodule

`default_nettype wire
